ntt_bfu_sched: RTL and testbench

- Upstream control stage for bfu_v1.
- Walks all LOGN stages of an in-place N-point NTT (op=0, Cooley-Tukey) or INTT (op=1, Gentleman-Sande).
- Each cycle it issues one butterfly: data-RAM read addresses for in1/in2, a twiddle-ROM address for gamma, and the bfu op bit.
- Delays the same address pair by the read-plus-BFU latency so the write port stores out1/out2 in place.

---
 rtl/ntt_bfu_sched.sv | 188 ++++++++++++++++++
 tb/tb_ntt_bfu_sched.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_bfu_sched.sv
// ntt_bfu_sched: address and control sequencer that sits in front of bfu_v1.
// It walks every stage of an in-place N-point NTT (Cooley-Tukey, op=0) or
// INTT (Gentleman-Sande, op=1) and issues one butterfly per cycle. It also
// replays each address pair after the read-plus-BFU latency so that the
// write port stores the results back in place.

module ntt_bfu_sched #(
    parameter int LOGN    = 8,
    parameter int RD_LAT  = 1,
    parameter int BFU_LAT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            op_in,
    output logic            busy,
    output logic            done,
    output logic            bfu_op,
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr1,
    output logic [LOGN-1:0] rd_addr2,
    output logic [LOGN-1:0] tw_addr,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr1,
    output logic [LOGN-1:0] wr_addr2
);

    localparam int N    = 1 << LOGN;
    localparam int HALF = N / 2;
    localparam int DLY  = RD_LAT + BFU_LAT;
    localparam int SW   = $clog2(LOGN + 1);
    localparam int CW   = $clog2(DLY + 1);

    localparam logic [LOGN-1:0] K_LAST = LOGN'(HALF - 1);
    localparam logic [LOGN-1:0] K_ONE  = LOGN'(1);
    localparam logic [SW-1:0]   S_LAST = SW'(LOGN - 1);
    localparam logic [SW-1:0]   S_ONE  = SW'(1);
    localparam logic [CW-1:0]   C_LAST = CW'(DLY - 1);
    localparam logic [CW-1:0]   C_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

    typedef struct packed {
        logic [LOGN-1:0] a1;
        logic [LOGN-1:0] a2;
        logic [LOGN-1:0] tw;
    } issue_t;

    state_t          state;
    logic [SW-1:0]   s;
    logic [LOGN-1:0] k;
    logic [CW-1:0]   cnt;

    // Butterfly k of stage s. Both transforms split k into a group index g
    // and an offset pos inside the group; only the half-span m and the
    // twiddle ordering differ. All spans are powers of two, so the
    // group base g*2m is a shift.
    function automatic issue_t calc_issue(input logic op, input logic [SW-1:0] st,
                                          input logic [LOGN-1:0] kk);
        issue_t res;
        int si, ki, sh, m, g, pos, a1, tw;
        si = int'(st);
        ki = int'(kk);
        if (!op) begin
            sh = LOGN - 1 - si;
            g  = ki >> sh;
            tw = (1 << si) + g;
        end else begin
            sh = si;
            g  = ki >> sh;
            tw = (N >> (si + 1)) - 1 - g;
        end
        m      = 1 << sh;
        pos    = ki & (m - 1);
        a1     = (g << (sh + 1)) | pos;
        res.a1 = LOGN'(a1);
        res.a2 = LOGN'(a1 + m);
        res.tw = LOGN'(tw);
        return res;
    endfunction

    // Stage/butterfly sequencing FSM with all read-side outputs registered.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values and simulation matches the synthesized netlist.
        if (rst) begin
            state    <= IDLE;
            s        <= '0;
            k        <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bfu_op   <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr1 <= '0;
            rd_addr2 <= '0;
            tw_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        bfu_op <= op_in;
                        s      <= '0;
                        k      <= '0;
                        busy   <= 1'b1;
                        rd_en  <= 1'b1;
                        {rd_addr1, rd_addr2, tw_addr} <= calc_issue(op_in, '0, '0);
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (k == K_LAST) begin
                        rd_en    <= 1'b0;
                        rd_addr1 <= '0;
                        rd_addr2 <= '0;
                        tw_addr  <= '0;
                        cnt      <= '0;
                        state    <= DRAIN;
                    end else begin
                        k <= k + K_ONE;
                        {rd_addr1, rd_addr2, tw_addr} <= calc_issue(bfu_op, s, k + K_ONE);
                    end
                end
                DRAIN: begin
                    // Hold off the next stage until the last write of this
                    // stage has landed, so no read sees stale data.
                    if (cnt == C_LAST) begin
                        if (s == S_LAST) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            s     <= s + S_ONE;
                            k     <= '0;
                            rd_en <= 1'b1;
                            {rd_addr1, rd_addr2, tw_addr} <= calc_issue(bfu_op, s + S_ONE, '0);
                            state <= RUN;
                        end
                    end else begin
                        cnt <= cnt + C_ONE;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [DLY-1:0]  dl_v;
    logic [LOGN-1:0] dl_a1 [DLY];
    logic [LOGN-1:0] dl_a2 [DLY];

    // Write-back delay line: replays {rd_en, rd_addr1, rd_addr2} DLY cycles later.
    always_ff @(posedge clk) begin
        // NOTE: the whole delay line is reset, not just the valid bits, so a
        // mid-transform reset cannot leak a stale write address to the outputs.
        if (rst) begin
            dl_v <= '0;
            for (int i = 0; i < DLY; i++) begin
                dl_a1[i] <= '0;
                dl_a2[i] <= '0;
            end
        end else begin
            dl_v[0]  <= rd_en;
            dl_a1[0] <= rd_addr1;
            dl_a2[0] <= rd_addr2;
            for (int i = 1; i < DLY; i++) begin
                dl_v[i]  <= dl_v[i-1];
                dl_a1[i] <= dl_a1[i-1];
                dl_a2[i] <= dl_a2[i-1];
            end
        end
    end

    assign wr_en    = dl_v[DLY-1];
    assign wr_addr1 = dl_a1[DLY-1];
    assign wr_addr2 = dl_a2[DLY-1];

endmodule

// File: tb/tb_ntt_bfu_sched.sv
// Testbench for ntt_bfu_sched: one LOGN=3 instance and one default LOGN=8
// instance, each compared cycle by cycle against a reference schedule built
// from the textbook nested butterfly loops of each transform.

module tb_ntt_bfu_sched;

    localparam int DLY = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       a_start = 1'b0, a_op = 1'b0;
    logic       a_busy, a_done, a_bfu_op, a_rd_en, a_wr_en;
    logic [2:0] a_rd_addr1, a_rd_addr2, a_tw_addr, a_wr_addr1, a_wr_addr2;

    logic       b_start = 1'b0, b_op = 1'b0;
    logic       b_busy, b_done, b_bfu_op, b_rd_en, b_wr_en;
    logic [7:0] b_rd_addr1, b_rd_addr2, b_tw_addr, b_wr_addr1, b_wr_addr2;

    ntt_bfu_sched #(.LOGN(3), .RD_LAT(1), .BFU_LAT(8)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .op_in(a_op),
        .busy(a_busy), .done(a_done), .bfu_op(a_bfu_op),
        .rd_en(a_rd_en), .rd_addr1(a_rd_addr1), .rd_addr2(a_rd_addr2), .tw_addr(a_tw_addr),
        .wr_en(a_wr_en), .wr_addr1(a_wr_addr1), .wr_addr2(a_wr_addr2)
    );

    ntt_bfu_sched dut_b (
        .clk(clk), .rst(rst), .start(b_start), .op_in(b_op),
        .busy(b_busy), .done(b_done), .bfu_op(b_bfu_op),
        .rd_en(b_rd_en), .rd_addr1(b_rd_addr1), .rd_addr2(b_rd_addr2), .tw_addr(b_tw_addr),
        .wr_en(b_wr_en), .wr_addr1(b_wr_addr1), .wr_addr2(b_wr_addr2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       op;
        logic       rd_en;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] tw;
        logic       wr_en;
        logic [7:0] w1;
        logic [7:0] w2;
    } obs_t;

    int checks   = 0;
    int failures = 0;

    int exp_a1 [1024];
    int exp_a2 [1024];
    int exp_tw [1024];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue order of every butterfly, straight from the nested group/offset loops.
    task automatic build_list(input int logn, input bit op);
        int n, idx;
        n   = 1 << logn;
        idx = 0;
        for (int s = 0; s < logn; s++) begin
            int half   = op ? (1 << s) : (n >> (s + 1));
            int groups = n / (2 * half);
            for (int j = 0; j < groups; j++) begin
                for (int i = 0; i < half; i++) begin
                    exp_a1[idx] = j * 2 * half + i;
                    exp_a2[idx] = j * 2 * half + i + half;
                    exp_tw[idx] = op ? (groups - 1 - j) : (groups + j);
                    idx++;
                end
            end
        end
    endtask

    // Expected outputs c cycles after the start-accepting edge's following cycle.
    function automatic obs_t expect_at(input int logn, input bit op, input int c);
        obs_t e;
        int n, half, per, total, st, off, cw;
        e     = '0;
        n     = 1 << logn;
        half  = n / 2;
        per   = half + DLY;
        total = logn * per;
        e.op   = op;
        e.busy = (c < total);
        e.done = (c == total);
        if (c < total) begin
            st  = c / per;
            off = c % per;
            if (off < half) begin
                e.rd_en = 1'b1;
                e.a1    = 8'(exp_a1[st * half + off]);
                e.a2    = 8'(exp_a2[st * half + off]);
                e.tw    = 8'(exp_tw[st * half + off]);
            end
        end
        cw = c - DLY;
        if (cw >= 0 && cw < total) begin
            st  = cw / per;
            off = cw % per;
            if (off < half) begin
                e.wr_en = 1'b1;
                e.w1    = 8'(exp_a1[st * half + off]);
                e.w2    = 8'(exp_a2[st * half + off]);
            end
        end
        return e;
    endfunction

    // Current DUT outputs; addresses are don't-care while their strobe is
    // expected low, unless raw observation is requested.
    function automatic obs_t observe(input bit inst, input obs_t e, input bit mask);
        obs_t o;
        if (inst) begin
            o.busy = b_busy; o.done = b_done; o.op = b_bfu_op; o.rd_en = b_rd_en;
            o.a1 = b_rd_addr1; o.a2 = b_rd_addr2; o.tw = b_tw_addr;
            o.wr_en = b_wr_en; o.w1 = b_wr_addr1; o.w2 = b_wr_addr2;
        end else begin
            o.busy = a_busy; o.done = a_done; o.op = a_bfu_op; o.rd_en = a_rd_en;
            o.a1 = 8'(a_rd_addr1); o.a2 = 8'(a_rd_addr2); o.tw = 8'(a_tw_addr);
            o.wr_en = a_wr_en; o.w1 = 8'(a_wr_addr1); o.w2 = 8'(a_wr_addr2);
        end
        if (mask && !e.rd_en) begin
            o.a1 = '0; o.a2 = '0; o.tw = '0;
        end
        if (mask && !e.wr_en) begin
            o.w1 = '0; o.w2 = '0;
        end
        return o;
    endfunction

    task automatic set_start(input bit inst, input bit v, input bit op);
        if (inst) begin
            b_start = v; b_op = op;
        end else begin
            a_start = v; a_op = op;
        end
    endtask

    // One transform: glitch_c pulses start (with the opposite op) at that
    // cycle, abort_c asserts rst at that cycle and checks the quiet aftermath.
    task automatic run_xform(input bit inst, input bit op, input int glitch_c, input int abort_c);
        int logn, total, wr_cnt, done_cnt;
        obs_t e, o;
        logn  = inst ? 8 : 3;
        total = logn * ((1 << logn) / 2 + DLY);
        build_list(logn, op);
        set_start(inst, 1'b1, op);
        tick();
        set_start(inst, 1'b0, op);
        wr_cnt   = 0;
        done_cnt = 0;
        for (int c = 0; c <= total + 1; c++) begin
            e = expect_at(logn, op, c);
            o = observe(inst, e, 1'b1);
            check($sformatf("seq%0d_op%0d_c%0d", inst, op, c), 64'(o), 64'(e));
            wr_cnt   += int'(o.wr_en);
            done_cnt += int'(o.done);
            if (c == abort_c) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                for (int z = 0; z <= DLY; z++) begin
                    o = observe(inst, '0, 1'b0);
                    check($sformatf("abort%0d_z%0d", inst, z), 64'(o), 64'(0));
                    tick();
                end
                return;
            end
            set_start(inst, c == glitch_c, ~op);
            tick();
        end
        set_start(inst, 1'b0, 1'b0);
        check($sformatf("wr_count%0d", inst), 64'(wr_cnt), 64'(logn * (1 << logn) / 2));
        check($sformatf("done_count%0d", inst), 64'(done_cnt), 64'(1));
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int gaps;
        bit rop;
        rst = 1'b1;
        repeat (2) tick();
        check("reset_a", 64'(observe(1'b0, '0, 1'b0)), 64'(0));
        check("reset_b", 64'(observe(1'b1, '0, 1'b0)), 64'(0));
        rst = 1'b0;
        tick();

        // start coincident with rst: reset must win
        rst = 1'b1;
        set_start(1'b0, 1'b1, 1'b1);
        tick();
        check("rst_wins", 64'(observe(1'b0, '0, 1'b0)), 64'(0));
        rst = 1'b0;
        set_start(1'b0, 1'b0, 1'b0);
        tick();
        check("rst_wins_idle", 64'(observe(1'b0, '0, 1'b0)), 64'(0));

        // small transform: plain NTT, INTT with busy-time start, start in FIN
        run_xform(1'b0, 1'b0, -1, -1);
        run_xform(1'b0, 1'b1, 20, -1);
        run_xform(1'b0, 1'b0, 39, -1);
        // reset on the 3rd read of stage 1, then a clean restart
        run_xform(1'b0, 1'b0, -1, 15);
        run_xform(1'b0, 1'b1, -1, -1);

        // full-size transforms
        run_xform(1'b1, 1'b0, -1, -1);
        run_xform(1'b1, 1'b1, 50, -1);
        run_xform(1'b1, 1'b1, -1, 139);
        for (int r = 0; r < 3; r++) begin
            gaps = int'($urandom_range(0, 5));
            repeat (gaps) tick();
            rop = 1'($urandom_range(0, 1));
            run_xform(1'b1, rop, int'($urandom_range(0, 1096)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
